// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder.
// FSM state encoding, read-strobe value and byte-merge helper.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam logic [3:0] WEN_READ = 4'b0000;

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_responder_sram_bytewise.sv
// Single-port word memory with per-byte write enables.
// Synchronous write, combinational read; contents are never reset.
module sram_bytewise #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches a request, stalls WAIT_STATES
// cycles, then commits and pulses dmem_ready for one cycle.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_din,
  input  logic        dmem_ena,
  input  logic [3:0]  dmem_wen,
  output logic [31:0] dmem_dout,
  output logic        dmem_ready,
  output logic        dmem_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic [3:0]  wen_q, wen_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [31:0] dout_q, dout_d;

  logic          commit;
  logic          in_range;
  logic          mem_we;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [31:0]   merged;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    wen_d   = wen_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dmem_ena) begin
          addr_d = dmem_addr;
          din_d  = dmem_din;
          wen_d  = dmem_wen;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESP;
            commit  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The access always uses the latched-next request, so the
  // zero-wait path commits on the same edge it accepts.
  assign in_range = (addr_d >> (AW + 2)) == 32'd0;
  assign idx      = addr_d[AW+1:2];
  assign merged   = merge_bytes(rd_word, din_d, wen_d);
  assign mem_we   = commit & in_range
                  & (wen_d != WEN_READ) & reset;

  always_comb begin
    ready_d = commit;
    err_d   = commit & ~in_range;
    dout_d  = (commit & in_range) ? merged : 32'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      din_q   <= 32'd0;
      wen_q   <= 4'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      wen_q   <= wen_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  sram_bytewise #(
    .DEPTH(DEPTH)
  ) u_sram (
    .clk  (clk),
    .we   (mem_we),
    .be   (wen_d),
    .addr (idx),
    .wdata(din_d),
    .rdata(rd_word)
  );

  assign dmem_ready = ready_q;
  assign dmem_err   = err_q;
  assign dmem_dout  = dout_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: two responders (0 and 3 wait states) driven
// with directed and random requests against a word-array model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;

  typedef struct {
    logic [31:0] dout;
    logic        err;
    longint      cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset [2];
  logic [31:0] addr  [2];
  logic [31:0] din   [2];
  logic        ena   [2];
  logic [3:0]  wen   [2];
  logic [31:0] dout  [2];
  logic        ready [2];
  logic        err   [2];

  int     vectors     = 0;
  int     miscompares = 0;
  longint cyc         = 0;
  bit     checking    = 1'b0;

  exp_t        sb  [2][$];
  logic [31:0] mdl [2][DEPTH];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_responder #(
      .DEPTH(DEPTH),
      .WAIT_STATES(g == 0 ? 0 : 3)
    ) u_dut (
      .clk       (clk),
      .reset     (reset[g]),
      .dmem_addr (addr[g]),
      .dmem_din  (din[g]),
      .dmem_ena  (ena[g]),
      .dmem_wen  (wen[g]),
      .dmem_dout (dout[g]),
      .dmem_ready(ready[g]),
      .dmem_err  (err[g])
    );

    always @(negedge clk) begin : mon
      exp_t e;
      if (checking) begin
        vectors++;
        if (ready[g] === 1'b1) begin
          if (sb[g].size() == 0) begin
            miscompares++;
            $display("FAIL spurious_ready u%0d cyc=%0d", g, cyc);
          end else begin
            e = sb[g].pop_front();
            if (dout[g] !== e.dout || err[g] !== e.err
                || cyc != e.cyc) begin
              miscompares++;
              $display("FAIL resp u%0d got dout=%h err=%b cyc=%0d want dout=%h err=%b cyc=%0d",
                       g, dout[g], err[g], cyc, e.dout, e.err, e.cyc);
            end
          end
        end else begin
          if (ready[g] !== 1'b0 || dout[g] !== 32'd0
              || err[g] !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_out u%0d got rdy=%b dout=%h err=%b want 0/0/0",
                     g, ready[g], dout[g], err[g]);
          end
          if (sb[g].size() > 0 && cyc > sb[g][0].cyc) begin
            miscompares++;
            $display("FAIL late_ready u%0d cyc=%0d want ready at %0d",
                     g, cyc, sb[g][0].cyc);
            void'(sb[g].pop_front());
          end
        end
      end
    end
  end

  function automatic int ws_of(input int u);
    return (u == 0) ? 0 : 3;
  endfunction

  // Word-array reference: fault if any bit above the index is set,
  // otherwise merge enabled bytes and return the resulting word.
  function automatic exp_t model(input int u, input logic [31:0] a,
                                 input logic [31:0] d,
                                 input logic [3:0] w,
                                 input longint at);
    exp_t        e;
    int          i;
    logic [31:0] word;
    e.cyc = at;
    if ((a >> ($clog2(DEPTH) + 2)) != 0) begin
      e.err  = 1'b1;
      e.dout = 32'd0;
    end else begin
      i    = int'(a / 4) % DEPTH;
      word = mdl[u][i];
      for (int b = 0; b < 4; b++)
        if (w[b]) word[8*b +: 8] = d[8*b +: 8];
      mdl[u][i] = word;
      e.err     = 1'b0;
      e.dout    = word;
    end
    return e;
  endfunction

  // Called at a negedge with the DUT idle, or in its RESP cycle
  // when from_resp is set; returns at the negedge of the RESP cycle.
  task automatic issue(input int u, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] w,
                       input bit from_resp);
    longint acc;
    addr[u] = a;
    din[u]  = d;
    wen[u]  = w;
    ena[u]  = 1'b1;
    if (from_resp) @(negedge clk);
    acc = cyc;
    sb[u].push_back(model(u, a, d, w, acc + ws_of(u) + 1));
    @(negedge clk);
    for (int k = 0; k < 40 && ready[u] !== 1'b1; k++) begin
      addr[u] = $urandom;
      din[u]  = $urandom;
      wen[u]  = 4'($urandom);
      @(negedge clk);
    end
    if (ready[u] !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_timeout u%0d addr=%h got no ready want ready", u, a);
    end
  endtask

  task automatic idle(input int u);
    ena[u] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  w;
    bit          b2b;
    for (int u = 0; u < 2; u++) begin
      reset[u] = 1'b0;
      ena[u]   = 1'b0;
      addr[u]  = 32'd0;
      din[u]   = 32'd0;
      wen[u]   = 4'd0;
    end
    repeat (3) @(negedge clk);
    reset[0] = 1'b1;
    reset[1] = 1'b1;
    checking = 1'b1;
    @(negedge clk);

    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 16; i++) begin
        issue(u, 32'(i * 4), $urandom, 4'hF, 1'b0);
        idle(u);
      end

    issue(0, 32'h10, 32'hAABBCCDD, 4'b1111, 1'b0); idle(0);
    issue(0, 32'h10, 32'h0, 4'b0000, 1'b0);        idle(0);
    issue(0, 32'h10, 32'h00001100, 4'b0010, 1'b0); idle(0);
    issue(0, 32'h10, 32'h0, 4'b0000, 1'b0);        idle(0);
    issue(0, 32'h13, 32'h0, 4'b0000, 1'b0);        idle(0);

    for (int u = 0; u < 2; u++) begin
      issue(u, 32'h1000, $urandom, 4'hF, 1'b0); idle(u);
      issue(u, 32'h0, 32'h0, 4'h0, 1'b0);       idle(u);
      issue(u, 32'h8000_0000, $urandom, 4'h0, 1'b0); idle(u);
    end

    for (int u = 0; u < 2; u++) begin
      issue(u, 32'h10, 32'h0, 4'h0, 1'b0);
      issue(u, 32'h14, 32'h0, 4'h0, 1'b1);
      issue(u, 32'h18, 32'h0, 4'h0, 1'b1);
      idle(u);
    end

    for (int u = 0; u < 2; u++) begin
      b2b = 1'b0;
      for (int n = 0; n < 50; n++) begin
        if ($urandom_range(0, 9) == 0)
          a = $urandom | 32'h1000;
        else
          a = 32'($urandom_range(0, 15) * 4) | ($urandom & 32'h3);
        w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
        issue(u, a, $urandom, w, b2b);
        b2b = 1'($urandom_range(0, 1));
        if (!b2b) idle(u);
      end
      if (b2b) idle(u);
    end

    addr[1] = 32'h20;
    din[1]  = 32'hDEAD_BEEF;
    wen[1]  = 4'hF;
    ena[1]  = 1'b1;
    @(negedge clk);
    ena[1]   = 1'b0;
    reset[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      vectors++;
      if (ready[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_ready got %b want 0", ready[1]);
      end
      if (k == 2) reset[1] = 1'b1;
    end
    issue(1, 32'h20, 32'h0, 4'h0, 1'b0); idle(1);
    issue(1, 32'h20, 32'h0, 4'h0, 1'b0); idle(1);

    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      vectors++;
      if (sb[u].size() != 0) begin
        miscompares++;
        $display("FAIL leftover u%0d got %0d pending want 0", u, sb[u].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words in the memory (power of two, at least 4).
REQ-002 SHALL have parameter WAIT_STATES, default 0, meaning extra stall cycles per access (0..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port dmem_addr, input, 32, byte address of the request.
REQ-006 SHALL have port dmem_din, input, 32, store data from the requester, byte-lane aligned.
REQ-007 SHALL have port dmem_ena, input, 1, request valid, held by the requester until dmem_ready.
REQ-008 SHALL have port dmem_wen, input, 4, byte-lane write enables; 4'b0000 means read.
REQ-009 SHALL have port dmem_dout, output, 32, full-word read data.
REQ-010 SHALL have port dmem_ready, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port dmem_err, output, 1, access fault, valid only with dmem_ready.

Function
REQ-012 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-013 IDLE with dmem_ena=1 SHALL latch addr, din and wen, then go to WAIT if WAIT_STATES>0, else to RESP.
REQ-014 WAIT SHALL count down a cycle counter loaded with WAIT_STATES-1 and go to RESP when the counter reaches 0.
REQ-015 The memory access SHALL commit on the clock edge entering RESP, using only the latched request values.
REQ-016 RESP SHALL assert dmem_ready=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-017 Latency from the acceptance edge to dmem_ready SHALL be WAIT_STATES+1 cycles.
REQ-018 Peak throughput SHALL be one access per WAIT_STATES+2 cycles.
REQ-019 Word index SHALL be addr[log2(DEPTH)+1:2]; addr[1:0] SHALL be ignored for indexing.
REQ-020 A write SHALL update byte i with din[8i+7:8i] only where wen[i]=1; all other bytes SHALL be unchanged.
REQ-021 In RESP, dmem_dout SHALL show the word after any write (write-first), so a store returns the merged word.
REQ-022 If addr[31:log2(DEPTH)+2] is nonzero, the access SHALL perform no write, and RESP SHALL show dmem_err=1 and dmem_dout=0.
REQ-023 Outside RESP, dmem_ready, dmem_err and dmem_dout SHALL all be 0.
REQ-024 Input changes during WAIT or RESP SHALL have no effect on the access in flight.
REQ-025 dmem_ena=1 in the cycle after RESP SHALL be treated as a new request.

Reset
REQ-026 reset=0 SHALL immediately force state IDLE, counter 0, latched request 0, and dmem_ready/dmem_err/dmem_dout to 0.
REQ-027 Reset in WAIT SHALL abort the access with no write and no dmem_ready pulse.
REQ-028 Memory contents SHALL NOT be cleared by reset.
REQ-029 After reset deasserts, the first rising edge with dmem_ena=1 SHALL be accepted.

Structure
REQ-030 The FSM state enum and the wen encoding constant (read = 4'b0000) SHALL live in the shared project constants package; WAIT_STATES and DEPTH SHALL remain local parameters.
REQ-031 Storage SHALL be one sub-module, sram_bytewise: single-port, DEPTH x 32 bits, 4 byte enables, synchronous write.
REQ-032 The FSM, wait counter and range check SHALL stay in dmem_responder.

Verification
REQ-033 WAIT_STATES=0: write addr 0x10, din 0xAABBCCDD, wen 4'b1111, then read 0x10 -> dout 0xAABBCCDD with ready one cycle after acceptance, err=0.
REQ-034 Byte lanes: after REQ-033, write din 0x00001100, wen 4'b0010 to 0x10 -> RESP dout 0xAABB11DD; a subsequent read returns 0xAABB11DD.
REQ-035 WAIT_STATES=3: read accepted at cycle N -> ready high only in cycle N+4; inputs toggled during wait change nothing.
REQ-036 DEPTH=1024: write to 0x00001000 -> ready=1, err=1, dout=0; reading word 0 afterwards is unchanged.
REQ-037 WAIT_STATES=3: reset=0 during WAIT of a write to 0x20 -> no ready pulse; reading 0x20 after reset returns the prior value.
REQ-038 Back-to-back: ena held high over 3 reads -> ready pulses spaced WAIT_STATES+2 cycles apart, with the correct data each time.
